// File: rtl/cordic_iterative_mm.sv
// Iterative CORDIC, one micro-rotation per clock, rotation or vectoring.
// Results are saturated to the external width; z wraps as an angle.
module cordic_iterative_mm #(
  parameter int N_FRAC     = 7,
  parameter int ITERATIONS = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     mode_i,
  input  logic signed [N_FRAC:0]   x_i,
  input  logic signed [N_FRAC:0]   y_i,
  input  logic signed [N_FRAC:0]   z_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [N_FRAC:0]   x_o,
  output logic signed [N_FRAC:0]   y_o,
  output logic signed [N_FRAC:0]   z_o,
  output logic                     ovf_o
);

  localparam int W  = N_FRAC + 3;
  localparam int ZW = N_FRAC + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST = 4'(ITERATIONS - 1);

  // atan(2^-i) with pi = 2^15
  localparam logic [15:0] T [16] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297,
    16'd651,  16'd325,  16'd162,  16'd81,
    16'd40,   16'd20,   16'd10,   16'd5,
    16'd2,    16'd1,    16'd0,    16'd0
  };

  logic [1:0]          state;
  logic [3:0]          iter;
  logic                mode;
  logic signed [W-1:0] x_q;
  logic signed [W-1:0] y_q;
  logic signed [ZW-1:0] z_q;

  logic signed [W-1:0]  x_sh;
  logic signed [W-1:0]  y_sh;
  logic signed [W-1:0]  x_n;
  logic signed [W-1:0]  y_n;
  logic signed [ZW-1:0] z_n;
  logic signed [ZW-1:0] ang;
  logic                 dir;

  logic [2:0]           x_top;
  logic [2:0]           y_top;
  logic                 x_ovf;
  logic                 y_ovf;
  logic signed [ZW-1:0] x_sat;
  logic signed [ZW-1:0] y_sat;

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);

  always_comb begin
    x_sh = x_q >>> iter;
    y_sh = y_q >>> iter;
    ang  = ZW'(T[iter] >> (15 - N_FRAC));
    dir  = mode ? y_q[W-1] : ~z_q[ZW-1];
    if (dir) begin
      x_n = x_q - y_sh;
      y_n = y_q + x_sh;
      z_n = z_q - ang;
    end else begin
      x_n = x_q + y_sh;
      y_n = y_q - x_sh;
      z_n = z_q + ang;
    end
  end

  // Out of range whenever the guard bits disagree with the sign
  assign x_top = x_n[W-1:N_FRAC];
  assign y_top = y_n[W-1:N_FRAC];
  assign x_ovf = ~(&x_top | ~|x_top);
  assign y_ovf = ~(&y_top | ~|y_top);
  assign x_sat = x_ovf ? {x_n[W-1], {N_FRAC{~x_n[W-1]}}}
                       : x_n[N_FRAC:0];
  assign y_sat = y_ovf ? {y_n[W-1], {N_FRAC{~y_n[W-1]}}}
                       : y_n[N_FRAC:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      iter  <= '0;
      mode  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      x_o   <= '0;
      y_o   <= '0;
      z_o   <= '0;
      ovf_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid_i) begin
            x_q   <= {{2{x_i[N_FRAC]}}, x_i};
            y_q   <= {{2{y_i[N_FRAC]}}, y_i};
            z_q   <= z_i;
            mode  <= mode_i;
            iter  <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          x_q  <= x_n;
          y_q  <= y_n;
          z_q  <= z_n;
          iter <= iter + 4'd1;
          if (iter == LAST) begin
            x_o   <= x_sat;
            y_o   <= y_sat;
            z_o   <= z_n;
            ovf_o <= x_ovf | y_ovf;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cordic_iterative_mm.md
# cordic_iterative_mm

Parametrised iterative CORDIC engine with run-time selectable rotation or vectoring mode, a configurable iteration count and data width, and ready/valid handshakes with output backpressure. It computes one micro-rotation per clock on a single shared datapath. It is the successor to the fixed-width, rotation-only iterative core and replaces it in the signal chain between the input sample registers and the output formatter.

## Interface
- N_FRAC, default 7: fractional bits; x/y/z are signed N_FRAC+1 bits; legal 4..15.
- ITERATIONS, default 6: micro-rotations per sample; legal 1..min(16, N_FRAC+1).
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-low; clears all state while low.
- in_valid_i  input  1  sample offered.
- in_ready_o  output  1  core accepts a sample this cycle.
- mode_i  input  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0); sampled on accept.
- x_i, y_i, z_i  input  N_FRAC+1 each  signed operands; x/y scale 2^N_FRAC = 1.0, z scale 2^N_FRAC = pi rad.
- out_valid_o  output  1  result valid, held until taken.
- out_ready_i  input  1  downstream takes the result.
- x_o, y_o, z_o  output  N_FRAC+1 each  result, registered.
- ovf_o  output  1  x_o or y_o was saturated; qualified by out_valid_o.

## Operation
- States: IDLE, CALC, DONE; reset state IDLE.
- IDLE: in_ready_o=1. On in_valid_i: load x,y (sign-extended to internal width W=N_FRAC+3), z (N_FRAC+1), latch mode, iteration counter i=0, go to CALC.
- CALC: one iteration per cycle using the registered values; after iteration ITERATIONS-1 go to DONE; in_ready_o=0.
- Direction d: rotation d=+1 if z>=0 else -1; vectoring d=+1 if y<0 else -1.
- d=+1: x'=x-(y>>>i), y'=y+(x>>>i), z'=z-A[i]; d=-1: signs of all three updates inverted.
- >>> is arithmetic (floor) shift; x/y arithmetic is W bits, never overflows for legal inputs; z arithmetic wraps modulo N_FRAC+1 bits (angle wrap is intended).
- A[i] = T[i] >>> (15-N_FRAC), with T (pi = 2^15) = 8192, 4836, 2555, 1297, 651, 325, 162, 81, 40, 20, 10, 5, 2, 1, 0, 0.
- No gain compensation: x/y carry CORDIC gain (~1.647 for large ITERATIONS).
- DONE: out_valid_o=1; x_o/y_o = W-bit values saturated to [-2^N_FRAC, 2^N_FRAC-1]; z_o = z; ovf_o = 1 if either x or y saturated. Outputs stable while out_valid_o=1 and out_ready_i=0. On out_ready_i go to IDLE.
- in_valid_i outside IDLE is ignored; no input buffering.

## Timing
- Reset values: in_ready_o=1 (IDLE), out_valid_o=0, x_o=y_o=z_o=0, ovf_o=0.
- Accept on edge E (in_valid_i & in_ready_o). Iterations complete on edges E+1..E+ITERATIONS; out_valid_o rises after edge E+ITERATIONS.
- Output handshake on edge F (out_valid_o & out_ready_i). out_valid_o low and in_ready_o high after F.
- Best-case throughput: one sample per ITERATIONS+2 cycles with out_ready_i tied high.
- in_ready_o and out_valid_o are never high in the same cycle.
- rst_i low mid-CALC or mid-DONE: immediate return to reset values, sample discarded. First accept is possible on the first edge after release.
- mode_i and data changes after accept have no effect on the sample in flight.

## Test plan
- N_FRAC=7, ITERATIONS=6, rotation: x=64, y=0, z=0 -> x_o=106, y_o=-2, z_o=-1, ovf_o=0; out_valid_o high exactly 6 edges after accept.
- Vectoring: x=64, y=64, z=0 -> internal x=150, so x_o=127, y_o=-1, z_o=33, ovf_o=1.
- Backpressure: out_ready_i low for 10 cycles after out_valid_o -> outputs constant, in_ready_o=0, pulses on in_valid_i ignored; release -> one transfer, then IDLE.
- Back-to-back samples with out_ready_i=1 -> accepts spaced exactly 8 cycles; results match golden model in order.
- Reset asserted during CALC (iteration 3) -> all outputs 0 and in_ready_o=1 immediately; the next sample returns correct values.
- Random sweep N_FRAC=11, ITERATIONS=12, both modes, 1000 samples -> bit-exact versus the integer reference model of the above equations.
